commutator_ctrl: RTL and testbench

COMMUTATOR_CTRL -- requirements
Module: commutator_ctrl

---
 rtl/commutator_pkg.sv | 13 +
 rtl/commutator_ctrl_route_seq.sv | 94 +++++++++
 rtl/commutator_ctrl.sv | 87 ++++++++
 tb/tb_commutator_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/commutator_pkg.sv
// Shared constants and FSM state encoding for the commutator route controller.
package commutator_pkg;

    localparam int NUM_IN_DEF  = 5;
    localparam int NUM_OUT_DEF = 3;
    localparam int SEL_W_DEF   = 3;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/commutator_ctrl_route_seq.sv
// Dwell/index sequencer: walks route-table entries 0..len, holding each for max(dwell,1) cycles.
module route_seq
    import commutator_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [IDX_W-1:0]   len,
    input  logic [DWELL_W-1:0] dwell,
    output logic               busy,
    output logic               ctl_valid,
    output logic [IDX_W-1:0]   idx,
    output logic               load_en,
    output logic [IDX_W-1:0]   load_idx
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   len_q, len_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               valid_q, valid_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        load_en  = 1'b0;
        load_idx = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d  = ST_RUN;
                    len_d    = (32'(len) > 32'(DEPTH - 1)) ? IDX_W'(DEPTH - 1) : len;
                    dwell_d  = (dwell == '0) ? DWELL_W'(1) : dwell;
                    cnt_d    = '0;
                    idx_d    = '0;
                    valid_d  = 1'b1;
                    load_en  = 1'b1;
                    load_idx = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == dwell_q - DWELL_W'(1)) begin
                    cnt_d    = '0;
                    idx_d    = (idx_q == len_q) ? '0 : idx_q + IDX_W'(1);
                    load_en  = 1'b1;
                    load_idx = idx_d;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign ctl_valid = valid_q;
    assign idx       = idx_q;

endmodule

// File: rtl/commutator_ctrl.sv
// Route-table commutator controller: checked table writes plus a sequenced, registered control word.
module commutator_ctrl
    import commutator_pkg::*;
#(
    parameter int NUM_IN  = NUM_IN_DEF,
    parameter int NUM_OUT = NUM_OUT_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [NUM_OUT*SEL_W-1:0]   wr_data,
    output logic                       wr_err,
    input  logic                       start,
    input  logic                       stop,
    input  logic [$clog2(DEPTH)-1:0]   len,
    input  logic [DWELL_W-1:0]         dwell,
    output logic [NUM_OUT*SEL_W-1:0]   control,
    output logic                       ctl_valid,
    output logic [$clog2(DEPTH)-1:0]   idx,
    output logic                       busy
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int DATA_W = NUM_OUT * SEL_W;

    logic [DATA_W-1:0] table_q [DEPTH];
    logic [DATA_W-1:0] table_d [DEPTH];
    logic [DATA_W-1:0] control_q, control_d;
    logic              err_q, err_d;
    logic              wr_acc, field_bad;
    logic              load_en;
    logic [IDX_W-1:0]  load_idx;

    route_seq #(
        .DEPTH   (DEPTH),
        .DWELL_W (DWELL_W),
        .IDX_W   (IDX_W)
    ) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .len       (len),
        .dwell     (dwell),
        .busy      (busy),
        .ctl_valid (ctl_valid),
        .idx       (idx),
        .load_en   (load_en),
        .load_idx  (load_idx)
    );

    assign wr_ready = !busy;
    assign wr_acc   = wr_valid && wr_ready;

    // control loads from the post-write table so a write coincident with start is visible.
    always_comb begin
        field_bad = 1'b0;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            if (32'(wr_data[k*SEL_W +: SEL_W]) >= 32'(NUM_IN)) field_bad = 1'b1;
        end
        table_d = table_q;
        if (wr_acc && !field_bad) table_d[wr_addr] = wr_data;
        err_d     = wr_acc && field_bad;
        control_d = load_en ? table_d[load_idx] : control_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) table_q[i] <= '0;
            control_q <= '0;
            err_q     <= 1'b0;
        end else begin
            table_q   <= table_d;
            control_q <= control_d;
            err_q     <= err_d;
        end
    end

    assign control = control_q;
    assign wr_err  = err_q;

endmodule

// File: tb/tb_commutator_ctrl.sv
// Self-checking bench for commutator_ctrl: directed vector table, corner sequences, random vs schedule model.
module tb_commutator_ctrl;

    localparam int NUM_IN  = 5;
    localparam int NUM_OUT = 3;
    localparam int SEL_W   = 3;
    localparam int DEPTH   = 8;
    localparam int DWELL_W = 8;
    localparam int DW      = NUM_OUT * SEL_W;
    localparam int AW      = 3;

    logic              clk = 1'b0;
    logic              rst_n, wr_valid, start, stop;
    logic [AW-1:0]     wr_addr, len;
    logic [DW-1:0]     wr_data;
    logic [DWELL_W-1:0] dwell;
    logic              wr_ready, wr_err, ctl_valid, busy;
    logic [DW-1:0]     control;
    logic [AW-1:0]     idx;

    int n_vec = 0;
    int n_bad = 0;

    commutator_ctrl #(
        .NUM_IN  (NUM_IN),
        .NUM_OUT (NUM_OUT),
        .SEL_W   (SEL_W),
        .DEPTH   (DEPTH),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_err    (wr_err),
        .start     (start),
        .stop      (stop),
        .len       (len),
        .dwell     (dwell),
        .control   (control),
        .ctl_valid (ctl_valid),
        .idx       (idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: the run is a schedule, idx = (cycles since start / dwell) mod (len+1).
    int          m_tab [DEPTH];
    bit          m_run, m_valid, m_err;
    int          m_n, m_len, m_dw, m_idx, m_ctl;

    function automatic bit bad_word(int w);
        for (int k = 0; k < NUM_OUT; k++)
            if (((w >> (k * SEL_W)) & ((1 << SEL_W) - 1)) >= NUM_IN) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_tab[i] = 0;
            m_run = 0; m_valid = 0; m_err = 0; m_n = 0; m_idx = 0; m_ctl = 0;
            m_len = 0; m_dw = 1;
            return;
        end
        m_err = 0;
        if (wr_valid && !m_run) begin
            if (bad_word(int'(wr_data))) m_err = 1;
            else m_tab[wr_addr] = int'(wr_data);
        end
        if (m_run) begin
            if (stop) begin
                m_run = 0;
                m_valid = 0;
            end else begin
                m_n++;
                m_idx = (m_n / m_dw) % (m_len + 1);
                m_ctl = m_tab[m_idx];
            end
        end else if (start && !stop) begin
            m_run = 1;
            m_valid = 1;
            m_len = (int'(len) > DEPTH - 1) ? DEPTH - 1 : int'(len);
            m_dw = (dwell == 0) ? 1 : int'(dwell);
            m_n = 0;
            m_idx = 0;
            m_ctl = m_tab[0];
        end
    endtask

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("busy", int'(busy), int'(m_run));
        chk("wr_ready", int'(wr_ready), int'(!m_run));
        chk("ctl_valid", int'(ctl_valid), int'(m_valid));
        chk("idx", int'(idx), m_idx);
        chk("control", int'(control), m_ctl);
        chk("wr_err", int'(wr_err), int'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic idle_in();
        rst_n = 1; wr_valid = 0; wr_addr = '0; wr_data = '0;
        start = 0; stop = 0; len = '0; dwell = '0;
    endtask

    typedef struct {
        logic          rst_n, wr_valid, start, stop;
        logic [AW-1:0] wr_addr, len;
        logic [DW-1:0] wr_data;
        logic [7:0]    dwell;
        logic [DW-1:0] e_ctl;
        logic          e_valid, e_err;
        logic [AW-1:0] e_idx;
    } vec_t;

    function automatic vec_t mk(logic r, logic wv, logic [AW-1:0] wa, logic [DW-1:0] wd,
                                logic st, logic sp, logic [AW-1:0] l, logic [7:0] d,
                                logic [DW-1:0] ec, logic ev, logic [AW-1:0] ei, logic ee);
        vec_t v;
        v.rst_n = r; v.wr_valid = wv; v.wr_addr = wa; v.wr_data = wd;
        v.start = st; v.stop = sp; v.len = l; v.dwell = d;
        v.e_ctl = ec; v.e_valid = ev; v.e_idx = ei; v.e_err = ee;
        return v;
    endfunction

    vec_t vecs [28];

    initial begin
        // reset, single-entry run (table[0]=0x0A3)
        vecs[0]  = mk(0, 0, 0, 9'h000, 0, 0, 0, 0, 9'h000, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 9'h0A3, 0, 0, 0, 0, 9'h000, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 9'h000, 1, 0, 0, 4, 9'h0A3, 1, 0, 0);
        vecs[3]  = mk(1, 0, 0, 9'h000, 0, 0, 0, 0, 9'h0A3, 1, 0, 0);
        vecs[4]  = mk(1, 0, 0, 9'h000, 0, 0, 0, 0, 9'h0A3, 1, 0, 0);
        vecs[5]  = mk(1, 0, 0, 9'h000, 0, 0, 0, 0, 9'h0A3, 1, 0, 0);
        vecs[6]  = mk(1, 0, 0, 9'h000, 0, 0, 0, 0, 9'h0A3, 1, 0, 0);
        vecs[7]  = mk(1, 0, 0, 9'h000, 0, 1, 0, 0, 9'h0A3, 0, 0, 0);
        // three entries, len=2 dwell=2
        vecs[8]  = mk(1, 1, 0, 9'h011, 0, 0, 0, 0, 9'h0A3, 0, 0, 0);
        vecs[9]  = mk(1, 1, 1, 9'h0D1, 0, 0, 0, 0, 9'h0A3, 0, 0, 0);
        vecs[10] = mk(1, 1, 2, 9'h104, 0, 0, 0, 0, 9'h0A3, 0, 0, 0);
        vecs[11] = mk(1, 0, 0, 9'h000, 1, 0, 2, 2, 9'h011, 1, 0, 0);
        vecs[12] = mk(1, 0, 0, 9'h000, 0, 0, 0, 0, 9'h011, 1, 0, 0);
        vecs[13] = mk(1, 0, 0, 9'h000, 0, 0, 0, 0, 9'h0D1, 1, 1, 0);
        vecs[14] = mk(1, 0, 0, 9'h000, 0, 0, 0, 0, 9'h0D1, 1, 1, 0);
        vecs[15] = mk(1, 0, 0, 9'h000, 0, 0, 0, 0, 9'h104, 1, 2, 0);
        vecs[16] = mk(1, 0, 0, 9'h000, 0, 0, 0, 0, 9'h104, 1, 2, 0);
        vecs[17] = mk(1, 0, 0, 9'h000, 0, 0, 0, 0, 9'h011, 1, 0, 0);
        vecs[18] = mk(1, 0, 0, 9'h000, 0, 0, 0, 0, 9'h011, 1, 0, 0);
        vecs[19] = mk(1, 0, 0, 9'h000, 0, 1, 0, 0, 9'h011, 0, 0, 0);
        // rejected writes (field 5, field 7) then len=0 readback
        vecs[20] = mk(1, 1, 0, 9'h005, 0, 0, 0, 0, 9'h011, 0, 0, 1);
        vecs[21] = mk(1, 0, 0, 9'h000, 0, 0, 0, 0, 9'h011, 0, 0, 0);
        vecs[22] = mk(1, 1, 0, 9'h1C0, 0, 0, 0, 0, 9'h011, 0, 0, 1);
        vecs[23] = mk(1, 0, 0, 9'h000, 0, 0, 0, 0, 9'h011, 0, 0, 0);
        vecs[24] = mk(1, 0, 0, 9'h000, 1, 0, 0, 1, 9'h011, 1, 0, 0);
        vecs[25] = mk(1, 0, 0, 9'h000, 0, 0, 0, 0, 9'h011, 1, 0, 0);
        vecs[26] = mk(1, 0, 0, 9'h000, 0, 1, 0, 0, 9'h011, 0, 0, 0);
        // start and stop together in IDLE
        vecs[27] = mk(1, 0, 0, 9'h000, 1, 1, 0, 0, 9'h011, 0, 0, 0);

        idle_in();
        for (int i = 0; i < 28; i++) begin
            rst_n = vecs[i].rst_n; wr_valid = vecs[i].wr_valid;
            wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
            start = vecs[i].start; stop = vecs[i].stop;
            len = vecs[i].len; dwell = vecs[i].dwell;
            tick();
            chk($sformatf("vec%0d.control", i), int'(control), int'(vecs[i].e_ctl));
            chk($sformatf("vec%0d.ctl_valid", i), int'(ctl_valid), int'(vecs[i].e_valid));
            chk($sformatf("vec%0d.idx", i), int'(idx), int'(vecs[i].e_idx));
            chk($sformatf("vec%0d.wr_err", i), int'(wr_err), int'(vecs[i].e_err));
            chk($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].e_valid));
        end

        // dwell=0 with len=7: one entry per cycle, wrap after idx 7
        idle_in();
        start = 1; len = 3'd7; dwell = 8'd0;
        tick();
        idle_in();
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("dwell0.idx", int'(idx), i % 8);
        end

        // stop mid-run holds control and idx
        stop = 1;
        tick();
        chk("stop.hold_idx", int'(idx), 1);
        chk("stop.valid", int'(ctl_valid), 0);
        idle_in();

        // write to entry 0 coincident with start
        wr_valid = 1; wr_addr = 0; wr_data = 9'h0E2; start = 1; len = 3'd1; dwell = 8'd3;
        tick();
        chk("wr_start.control", int'(control), 9'h0E2);
        idle_in();
        repeat (5) tick();
        // start while running is ignored; rejected write while running stays silent
        start = 1; wr_valid = 1; wr_data = 9'h1FF;
        tick();
        idle_in();
        repeat (3) tick();

        // one-cycle reset mid-run
        rst_n = 0;
        tick();
        idle_in();
        chk("rst.control", int'(control), 0);
        chk("rst.idx", int'(idx), 0);
        chk("rst.valid", int'(ctl_valid), 0);
        chk("rst.wr_ready", int'(wr_ready), 1);
        start = 1; len = 3'd7; dwell = 8'd1;
        tick();
        idle_in();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rst.table_zero", int'(control), 0);
        end
        stop = 1;
        tick();

        // randomized traffic against the schedule model
        for (int c = 0; c < 3000; c++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_addr  = AW'($urandom_range(0, DEPTH - 1));
            wr_data  = DW'($urandom);
            start    = ($urandom_range(0, 9) == 0);
            stop     = ($urandom_range(0, 24) == 0);
            len      = AW'($urandom_range(0, DEPTH - 1));
            dwell    = DWELL_W'($urandom_range(0, 4));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
